// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO result registers
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   a_raw;
   logic [2*WIDTH-1:0] work;
   logic [CW-1:0]      counter;
   logic               prod_neg;
   logic               quot_neg;
   logic               rem_neg;
   logic               div_zero;

   logic               is_signed;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      is_signed = ~op[0];
      mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (b_mag[0] ? {1'b0, a_mag} : '0);
      // Restoring divide: dividend bits enter the partial remainder MSB first from a_mag.
      div_shift = {work[2*WIDTH-1:WIDTH], a_mag[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_mag};
      prod_fix  = prod_neg ? (~work + 1'b1) : work;
      quot_fix  = quot_neg ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
      rem_fix   = rem_neg ? (~work[2*WIDTH-1:WIDTH] + 1'b1) : work[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         op_r     <= '0;
         a_mag    <= '0;
         b_mag    <= '0;
         a_raw    <= '0;
         work     <= '0;
         counter  <= '0;
         prod_neg <= 1'b0;
         quot_neg <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_r     <= op;
                  a_raw    <= rs_data;
                  a_mag    <= (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
                  b_mag    <= (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
                  prod_neg <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                  quot_neg <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                  rem_neg  <= is_signed && rs_data[WIDTH-1];
                  div_zero <= (rt_data == '0);
                  work     <= '0;
                  counter  <= '0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end else begin
                  if (hi_we) hi <= rs_data;
                  if (lo_we) lo <= rs_data;
               end
            end
            CALC: begin
               if (op_r[1]) begin
                  a_mag <= {a_mag[WIDTH-2:0], 1'b0};
                  if (!div_diff[WIDTH])
                     work <= {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
                  else
                     work <= {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
               end else begin
                  b_mag <= {1'b0, b_mag[WIDTH-1:1]};
                  work  <= {mul_sum, work[WIDTH-1:1]};
               end
               counter <= counter + 1'b1;
               if (counter == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               if (!op_r[1]) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else if (div_zero) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors = 0;
   int errors  = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at the negedge after the accepting edge; returns at the negedge where done is seen.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
      int lat, bc;
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; rs_data = ~a; rt_data = ~b;
      wait_done(lat, bc);
      chk({tag, "_latency"}, lat, 33);
      chk({tag, "_busy_cycles"}, bc, 33);
      chk({tag, "_busy_at_done"}, {31'b0, busy}, 0);
      chk({tag, "_hi"}, hi, ehi);
      chk({tag, "_lo"}, lo, elo);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {31'b0, done}, 0);
   endtask

   initial begin
      int lat, bc, done_seen;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      chk("reset_busy", {31'b0, busy}, 0);
      chk("reset_done", {31'b0, done}, 0);

      lo_we = 1'b1; rs_data = 32'hA5A5_A5A5;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo_lo", lo, 32'hA5A5_A5A5);
      chk("mtlo_hi", hi, 0);
      chk("mtlo_done", {31'b0, done}, 0);

      hi_we = 1'b1; rs_data = 32'h0000_1111;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_hi", hi, 32'h0000_1111);
      chk("mthi_lo", lo, 32'hA5A5_A5A5);

      do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
      do_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
      do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      do_op("div_zero",  2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
      do_op("mult_min",  2'b00, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'd0);

      // start wins over MTHI/MTLO; start and hi_we held through busy are ignored
      start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; hi_we = 1'b1; lo_we = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("start_wins_hi", hi, 32'hFFFF_FFFF);
      chk("start_wins_lo", lo, 32'd0);
      op = 2'b01; rs_data = 32'd55; rt_data = 32'd3; lo_we = 1'b0;
      repeat (5) @(negedge clk);
      chk("hi_we_busy_hi", hi, 32'hFFFF_FFFF);
      chk("start_held_busy", {31'b0, busy}, 1);
      wait_done(lat, bc);
      chk("held_latency", lat, 33 - 5);
      chk("held_hi", hi, 32'd2);
      chk("held_lo", lo, 32'd14);
      hi_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", {31'b0, busy}, 1);
      chk("b2b_done_low", {31'b0, done}, 0);
      wait_done(lat, bc);
      chk("b2b_latency", lat, 33);
      chk("b2b_hi", hi, 32'd0);
      chk("b2b_lo", lo, 32'd165);

      // reset in the middle of a MULT discards the operation
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs_data = 32'd5; rt_data = 32'd6;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_hi", hi, 0);
      chk("midreset_lo", lo, 0);
      chk("midreset_busy", {31'b0, busy}, 0);
      chk("midreset_done", {31'b0, done}, 0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) done_seen++;
         @(negedge clk);
      end
      chk("midreset_no_done", done_seen, 0);
      chk("midreset_lo_after", lo, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
